display_capture: RTL and testbench

//  Receive side of the 4-digit multiplexed 7-segment interface: samples the active-low

---
 rtl/display_capture_if.sv | 36 +++
 rtl/display_capture.sv | 190 +++++++++++++++++++
 tb/tb_display_capture.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/display_capture_if.sv
// Pin-side bundle of the display capture block: the sampled active-low display
// bus going in, the reconstructed digits and status coming out.
// There is no valid/ready handshake here. The inputs are free-running pins.
// digit_*, nibble_*, nibble_valid and stale are level outputs that hold between
// captures. frame_done is a single-cycle pulse.
interface display_capture_if;
  logic [6:0] segment_in;
  logic [3:0] digit_enable_in;
  logic [6:0] digit_0;
  logic [6:0] digit_1;
  logic [6:0] digit_2;
  logic [6:0] digit_3;
  logic [3:0] nibble_0;
  logic [3:0] nibble_1;
  logic [3:0] nibble_2;
  logic [3:0] nibble_3;
  logic [3:0] nibble_valid;
  logic       frame_done;
  logic [3:0] stale;

  // Drives the display pins and observes the capture results.
  modport master (
    output segment_in, digit_enable_in,
    input  digit_0, digit_1, digit_2, digit_3,
    input  nibble_0, nibble_1, nibble_2, nibble_3,
    input  nibble_valid, frame_done, stale
  );

  // The capture block itself.
  modport slave (
    input  segment_in, digit_enable_in,
    output digit_0, digit_1, digit_2, digit_3,
    output nibble_0, nibble_1, nibble_2, nibble_3,
    output nibble_valid, frame_done, stale
  );
endinterface

// File: rtl/display_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus. The block synchronises
// the pins and waits for a stable digit phase. It then latches the segment
// pattern into the addressed digit and decodes that pattern to a hex nibble.
module display_capture #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic             clk,
  input logic             reset,
  display_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [TW-1:0] STALE_MAX = TW'(TIMEOUT_CYCLES);

  logic [6:0]    seg_sync [SYNC_STAGES];
  logic [3:0]    en_sync  [SYNC_STAGES];
  logic [6:0]    seg_s;
  logic [3:0]    en_s;
  logic [10:0]   prev_q;
  logic          same_sample;
  logic          phase_valid;
  logic [1:0]    tgt;
  logic [3:0]    tgt_onehot;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_next;
  logic          capture;
  logic [6:0]    pattern;
  logic [3:0]    dec_nib;
  logic          dec_vld;
  logic [6:0]    digit_q  [4];
  logic [3:0]    nibble_q [4];
  logic [3:0]    nvalid_q;
  logic [3:0]    mask_q;
  logic [3:0]    mask_next;
  logic          frame_q;
  logic [TW-1:0] stale_cnt [4];
  logic [3:0]    stale_flag;

  // Glyph table. The input is the active-high pattern; the result is {valid, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0;
    case (p)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  // Input synchronisers; everything downstream sees only the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= '0;
        en_sync[i]  <= '0;
      end
    end else begin
      seg_sync[0] <= bus.segment_in;
      en_sync[0]  <= bus.digit_enable_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= seg_sync[i-1];
        en_sync[i]  <= en_sync[i-1];
      end
    end
  end

  assign seg_s   = seg_sync[SYNC_STAGES-1];
  assign en_s    = en_sync[SYNC_STAGES-1];
  assign pattern = ~seg_s;

  // Map the single low enable to its digit. Blank and multi-low states are idle.
  always_comb begin
    phase_valid = 1'b0;
    tgt         = 2'd0;
    case (en_s)
      4'b1110: begin phase_valid = 1'b1; tgt = 2'd3; end
      4'b1101: begin phase_valid = 1'b1; tgt = 2'd2; end
      4'b1011: begin phase_valid = 1'b1; tgt = 2'd1; end
      4'b0111: begin phase_valid = 1'b1; tgt = 2'd0; end
      default: begin phase_valid = 1'b0; tgt = 2'd0; end
    endcase
  end

  // Stability count: restart on any change, hold once saturated so a phase captures once.
  always_comb begin
    same_sample = ({en_s, seg_s} == prev_q);
    cnt_next    = CNT_ONE;
    if (!phase_valid) begin
      cnt_next = '0;
    end else if (same_sample) begin
      cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end
    // A changed sample always restarts, so with STABLE_CYCLES=1 each new value captures.
    capture    = phase_valid && (cnt_next == CNT_MAX) && ((cnt_q != CNT_MAX) || !same_sample);
    tgt_onehot = capture ? (4'b0001 << tgt) : 4'b0000;
    {dec_vld, dec_nib} = decode(pattern);
    mask_next  = mask_q | tgt_onehot;
  end

  // Previous-sample register and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= {en_s, seg_s};
      cnt_q  <= cnt_next;
    end
  end

  // Latch the captured pattern and its decode into the addressed digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        digit_q[i]  <= '0;
        nibble_q[i] <= '0;
      end
      nvalid_q <= '0;
    end else if (capture) begin
      digit_q[tgt]  <= pattern;
      nibble_q[tgt] <= dec_nib;
      nvalid_q[tgt] <= dec_vld;
    end
  end

  // Frame tracking. The completing capture closes the frame and the mask restarts empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      frame_q <= 1'b0;
    end else if (mask_next == 4'hF) begin
      mask_q  <= '0;
      frame_q <= 1'b1;
    end else begin
      mask_q  <= mask_next;
      frame_q <= 1'b0;
    end
  end

  // Per-digit staleness timers, cleared by a capture of that digit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        stale_cnt[i] <= '0;
      end else if (tgt_onehot[i]) begin
        stale_cnt[i] <= '0;
      end else if (stale_cnt[i] != STALE_MAX) begin
        stale_cnt[i] <= stale_cnt[i] + TW'(1);
      end
    end
  end

  // A digit is stale while its timer sits at the limit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stale_flag[i] = (stale_cnt[i] == STALE_MAX);
    end
  end

  assign bus.digit_0      = digit_q[0];
  assign bus.digit_1      = digit_q[1];
  assign bus.digit_2      = digit_q[2];
  assign bus.digit_3      = digit_q[3];
  assign bus.nibble_0     = nibble_q[0];
  assign bus.nibble_1     = nibble_q[1];
  assign bus.nibble_2     = nibble_q[2];
  assign bus.nibble_3     = nibble_q[3];
  assign bus.nibble_valid = nvalid_q;
  assign bus.frame_done   = frame_q;
  assign bus.stale        = stale_flag;
endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: directed display phases, a capture/frame
// scoreboard driven by a negedge monitor, and direct checks at key edges.
module tb_display_capture;
  logic clk = 1'b0;
  logic reset;

  // Clock and DUT
  always #5 clk = ~clk;

  display_capture_if dif();

  display_capture #(
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(dif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [6:0]  model_dig[4];
  logic [3:0]  model_mask;
  logic [7:0]  frames_expected = 8'd0;
  logic [7:0]  frames_seen = 8'd0;
  logic [6:0]  dig_act[4];
  logic [3:0]  nib_act[4];
  logic [6:0]  shadow[4];
  logic [13:0] mon_e;

  always_comb begin
    dig_act[0] = dif.digit_0;
    dig_act[1] = dif.digit_1;
    dig_act[2] = dif.digit_2;
    dig_act[3] = dif.digit_3;
    nib_act[0] = dif.nibble_0;
    nib_act[1] = dif.nibble_1;
    nib_act[2] = dif.nibble_2;
    nib_act[3] = dif.nibble_3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Record an expected capture in the model: value change -> scoreboard, mask -> frame.
  task automatic push_capture(input int idx, input logic [6:0] pat, input logic [3:0] nib,
                              input logic vld);
    if (model_dig[idx] != pat) exp_q.push_back({2'(idx), pat, nib, vld});
    model_dig[idx]  = pat;
    model_mask[idx] = 1'b1;
    if (model_mask == 4'hF) begin
      frames_expected = frames_expected + 8'd1;
      frame_q.push_back(frames_expected);
      model_mask = 4'h0;
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] pat);
    dif.digit_enable_in = en;
    dif.segment_in      = ~pat;
  endtask

  // Hold one display phase for n cycles; at least 4 steady cycles means a capture.
  task automatic phase(input logic [3:0] en, input logic [6:0] pat, input logic [3:0] nib,
                       input logic vld, input int n);
    int idx;
    case (en)
      4'b1110: idx = 3;
      4'b1101: idx = 2;
      4'b1011: idx = 1;
      4'b0111: idx = 0;
      default: idx = -1;
    endcase
    if (idx >= 0 && n >= 4) push_capture(idx, pat, nib, vld);
    drive(en, pat);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    drive(4'b1111, 7'h00);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_digit_0"}, dif.digit_0, 7'h00);
    check({tag, "_digit_1"}, dif.digit_1, 7'h00);
    check({tag, "_digit_2"}, dif.digit_2, 7'h00);
    check({tag, "_digit_3"}, dif.digit_3, 7'h00);
    check({tag, "_nibbles"}, {dif.nibble_3, dif.nibble_2, dif.nibble_1, dif.nibble_0}, 16'h0000);
    check({tag, "_nibble_valid"}, dif.nibble_valid, 4'h0);
    check({tag, "_frame_done"}, dif.frame_done, 1'b0);
    check({tag, "_stale"}, dif.stale, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_dig[i] = 7'h00;
    model_mask = 4'h0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every digit change and every frame_done pulse consumes an expectation.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) shadow[i] <= 7'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dig_act[i] !== shadow[i]) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_capture digit_%0d: got %02h, expected unchanged %02h",
                     i, dig_act[i], shadow[i]);
          end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("capture_digit_%0d", i),
                  {2'(i), dig_act[i], nib_act[i], dif.nibble_valid[i]}, mon_e);
          end
          shadow[i] <= dig_act[i];
        end
      end
      if (dif.frame_done !== 1'b0) begin
        if (frame_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_frame_done: got %b, expected 0", dif.frame_done);
        end else begin
          check("frame_done_seq", frames_seen + 8'd1, frame_q.pop_front());
        end
        frames_seen <= frames_seen + 8'd1;
      end
    end
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    drive(4'b1111, 7'h00);
    do_reset("reset");

    // 1: digit_3 = 3F lands on the 6th edge after the pins settle
    push_capture(3, 7'h3F, 4'h0, 1'b1);
    drive(4'b1110, 7'h3F);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t1_digit_3_before_edge6", dif.digit_3, 7'h00);
    @(posedge clk);
    @(negedge clk);
    check("t1_digit_3", dif.digit_3, 7'h3F);
    check("t1_nibble_3", dif.nibble_3, 4'h0);
    check("t1_valid_3", dif.nibble_valid[3], 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // 2: two full rounds of all four digits, one frame per round
    for (int r = 0; r < 2; r++) begin
      phase(4'b1110, 7'h06, 4'h1, 1'b1, 64);
      phase(4'b1101, 7'h5B, 4'h2, 1'b1, 64);
      phase(4'b1011, 7'h4F, 4'h3, 1'b1, 64);
      phase(4'b0111, 7'h66, 4'h4, 1'b1, 64);
    end
    check("t2_nibble_0", dif.nibble_0, 4'h4);
    check("t2_nibble_1", dif.nibble_1, 4'h3);
    check("t2_nibble_2", dif.nibble_2, 4'h2);
    check("t2_nibble_3", dif.nibble_3, 4'h1);
    check("t2_nibble_valid", dif.nibble_valid, 4'hF);

    // 3: segment toggling every 3 cycles never settles long enough
    for (int k = 0; k < 8; k++) begin
      phase(4'b1101, (k % 2 == 0) ? 7'h7F : 7'h6F, 4'h0, 1'b0, 3);
    end
    check("t3_digit_2_held", dif.digit_2, 7'h5B);

    // 4: two-low and blank enables are idle
    phase(4'b1100, 7'h3F, 4'h0, 1'b0, 50);
    phase(4'b1111, 7'h3F, 4'h0, 1'b0, 50);
    check("t4_digit_0", dif.digit_0, 7'h66);
    check("t4_digit_1", dif.digit_1, 7'h4F);
    check("t4_digit_3", dif.digit_3, 7'h06);
    check("t4_stale", dif.stale, 4'h0);

    // 5: starve digit_1 past the timeout, then recapture it
    for (int k = 0; k < 22; k++) begin
      phase(4'b0111, 7'h66, 4'h4, 1'b1, 64);
      phase(4'b1101, 7'h5B, 4'h2, 1'b1, 64);
      phase(4'b1110, 7'h06, 4'h1, 1'b1, 64);
    end
    check("t5_stale_set", dif.stale, 4'b0010);
    push_capture(1, 7'h77, 4'hA, 1'b1);
    drive(4'b1011, 7'h77);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_stale_before_capture", dif.stale[1], 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("t5_stale_cleared", dif.stale, 4'b0000);
    check("t5_digit_1", dif.digit_1, 7'h77);
    check("t5_nibble_1", dif.nibble_1, 4'hA);
    repeat (58) @(posedge clk);
    #1;

    // 6: reset after two captures discards the partial frame
    phase(4'b1110, 7'h7D, 4'h6, 1'b1, 64);
    phase(4'b1101, 7'h39, 4'hC, 1'b1, 64);
    check("t6_nibble_3_pre", dif.nibble_3, 4'h6);
    check("t6_nibble_2_pre", dif.nibble_2, 4'hC);
    do_reset("t6_reset");
    phase(4'b0111, 7'h79, 4'hE, 1'b1, 64);
    // 7: non-glyph pattern is kept, flagged invalid, and still counts in the frame
    phase(4'b1011, 7'h49, 4'h0, 1'b0, 64);
    check("t7_digit_1", dif.digit_1, 7'h49);
    check("t7_nibble_1", dif.nibble_1, 4'h0);
    check("t7_valid_1", dif.nibble_valid[1], 1'b0);
    phase(4'b1101, 7'h5E, 4'hD, 1'b1, 64);
    phase(4'b1110, 7'h71, 4'hF, 1'b1, 64);
    check("t6_nibble_valid", dif.nibble_valid, 4'b1101);
    check("t6_frames", frames_seen, 8'd4);

    phase(4'b1111, 7'h00, 4'h0, 1'b0, 10);
    check("exp_q_drained", exp_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
